// File: rtl/regs_cmd_pkg.sv
// regs_cmd_pkg: shared state encoding, command fields and register map for the command path
package regs_cmd_pkg;
  localparam int ADDR_W        = 6;
  localparam int DATA_W        = 8;
  localparam int CMD_WR_BIT    = 7;
  localparam int CMD_BURST_BIT = 6;
  localparam logic [ADDR_W-1:0] REG_PERIOD_LO   = 6'h00;
  localparam logic [ADDR_W-1:0] REG_PERIOD_HI   = 6'h01;
  localparam logic [ADDR_W-1:0] REG_COMPARE0_LO = 6'h02;
  localparam logic [ADDR_W-1:0] REG_COMPARE1_LO = 6'h03;
  localparam logic [ADDR_W-1:0] REG_LAST        = 6'h3F;
  typedef enum logic [2:0] {
    IDLE,
    LEN,
    WDATA,
    WPULSE,
    RSTB,
    TXW
  } state_e;
endpackage

// File: rtl/regs_cmd_ctrl.sv
// regs_cmd_ctrl: parses read/write byte commands and drives the register file strobes
module regs_cmd_ctrl #(
  parameter int ADDR_W = regs_cmd_pkg::ADDR_W,
  parameter int DATA_W = regs_cmd_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rx_byte,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [DATA_W-1:0] tx_byte,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic              frame_abort,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_write,
  input  logic [DATA_W-1:0] data_read,
  output logic              busy,
  output logic              err
);
  import regs_cmd_pkg::*;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic              rx_fire;
  logic              more;

  assign rx_ready   = rst_n & (state_q == IDLE || state_q == LEN || state_q == WDATA);
  assign rx_fire    = rx_valid & rx_ready;
  assign more       = cnt_q > DATA_W'(1);
  assign tx_valid   = state_q == TXW;
  assign write      = state_q == WPULSE;
  assign read       = state_q == RSTB;
  assign busy       = state_q != IDLE;
  assign err        = err_q;
  assign addr       = addr_q;
  assign data_write = data_q;
  assign tx_byte    = tx_q;

  // Register all controller state; reset returns to IDLE with cleared outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      tx_q    <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  // Next state and datapath; abort wins and discards any byte accepted this cycle
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    tx_d    = tx_q;
    wr_d    = wr_q;
    err_d   = 1'b0;
    if (frame_abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: if (rx_fire) begin
          addr_d  = rx_byte[ADDR_W-1:0];
          cnt_d   = DATA_W'(1);
          wr_d    = rx_byte[CMD_WR_BIT];
          state_d = rx_byte[CMD_BURST_BIT] ? LEN : rx_byte[CMD_WR_BIT] ? WDATA : RSTB;
        end
        LEN: if (rx_fire) begin
          cnt_d   = rx_byte;
          err_d   = rx_byte == '0;
          state_d = (rx_byte == '0) ? IDLE : wr_q ? WDATA : RSTB;
        end
        WDATA: if (rx_fire) begin
          data_d  = rx_byte;
          state_d = WPULSE;
        end
        WPULSE: begin
          addr_d  = addr_q + ADDR_W'(1);
          cnt_d   = cnt_q - DATA_W'(1);
          state_d = more ? WDATA : IDLE;
        end
        RSTB: begin
          tx_d    = data_read;
          state_d = TXW;
        end
        TXW: if (tx_ready) begin
          addr_d  = addr_q + ADDR_W'(1);
          cnt_d   = cnt_q - DATA_W'(1);
          state_d = more ? RSTB : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regs_cmd_ctrl.sv
// tb_regs_cmd_ctrl: scoreboard bench for the register command sequencer
module tb_regs_cmd_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;
  logic       frame_abort;
  logic       read;
  logic       write;
  logic [5:0] addr;
  logic [7:0] data_write;
  logic [7:0] data_read;
  logic       busy;
  logic       err;

  logic [7:0]  mem     [64];
  logic [7:0]  ref_mem [64];
  logic [13:0] exp_wr  [$];
  logic [7:0]  exp_tx  [$];
  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, cyc = 0;
  int wr_prev = 0, wr_last = 0, tx_prev = 0, tx_last = 0;

  regs_cmd_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready), .frame_abort(frame_abort),
    .read(read), .write(write), .addr(addr), .data_write(data_write), .data_read(data_read),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  assign data_read = mem[addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    rx_byte  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 200) begin step(); n++; end
    if (n >= 200) check("rx_timeout", 0, 1);
    step();
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin step(); n++; end
    if (n >= 200) check("idle_timeout", 0, 1);
  endtask

  task automatic exp_write(input logic [5:0] a, input logic [7:0] d);
    exp_wr.push_back({a, d});
    ref_mem[a] = d;
  endtask

  task automatic exp_read(input logic [5:0] a);
    exp_tx.push_back(ref_mem[a]);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sample at the falling edge, compare strobes and tx handshakes against the queues
  always @(negedge clk) begin
    if (rst_n) begin
      if (write) begin
        wr_cnt++;
        wr_prev = wr_last;
        wr_last = cyc;
        if (exp_wr.size() == 0) check("wr_unexpected", {addr, data_write}, 0);
        else begin
          logic [13:0] e;
          e = exp_wr.pop_front();
          check("wr_addr", addr, e[13:8]);
          check("wr_data", data_write, e[7:0]);
        end
        mem[addr] = data_write;
      end
      if (read) rd_cnt++;
      if (err) err_cnt++;
      if (tx_valid && tx_ready) begin
        tx_prev = tx_last;
        tx_last = cyc;
        if (exp_tx.size() == 0) check("tx_unexpected", tx_byte, 0);
        else check("tx_byte", tx_byte, exp_tx.pop_front());
      end
    end
  end

  initial begin
    int w0, r0, e0;
    logic [7:0] held;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 8'(i);
      ref_mem[i] = 8'(i);
    end
    rst_n = 1'b0; rx_byte = '0; rx_valid = 1'b0; tx_ready = 1'b1; frame_abort = 1'b0;
    step(); step();
    check("rst_rx_ready", rx_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_strobes", {read, write, tx_valid, err}, 0);
    check("rst_regs", {addr, data_write, tx_byte}, 0);
    rst_n = 1'b1;
    step();
    check("idle_rx_ready", rx_ready, 1);

    exp_write(6'h03, 8'h5A);
    send(8'h83);
    send(8'h5A);
    check("single_wr_pulse", write, 1);
    step();
    check("single_wr_len", write, 0);
    exp_read(6'h03);
    send(8'h03);
    check("single_rd_strobe", read, 1);
    step();
    check("single_rd_valid", tx_valid, 1);
    wait_idle();

    w0 = wr_cnt;
    exp_write(6'h00, 8'h10);
    exp_write(6'h01, 8'h27);
    send(8'hC0); send(8'h02); send(8'h10); send(8'h27);
    wait_idle();
    check("burst_wr_count", wr_cnt - w0, 2);
    check("burst_wr_period", wr_last - wr_prev, 2);
    exp_read(6'h00);
    exp_read(6'h01);
    send(8'h40); send(8'h02);
    wait_idle();
    check("burst_rd_period", tx_last - tx_prev, 2);
    check("period_model", {mem[1], mem[0]}, 16'h2710);

    tx_ready = 1'b0;
    r0 = rd_cnt;
    for (int i = 0; i < 3; i++) exp_read(6'(8'h0C + i));
    send(8'h4C); send(8'h03);
    for (int b = 0; b < 3; b++) begin
      int n = 0;
      while (!tx_valid && n < 50) begin step(); n++; end
      if (n >= 50) check("tx_timeout", 0, 1);
      held = tx_byte;
      for (int s = 0; s < 5; s++) begin
        step();
        check("stall_hold", {tx_valid, tx_byte}, {1'b1, held});
      end
      tx_ready = 1'b1;
      step();
      tx_ready = 1'b0;
    end
    wait_idle();
    tx_ready = 1'b1;
    check("bp_read_strobes", rd_cnt - r0, 3);

    exp_write(6'h3F, 8'hAA);
    exp_write(6'h00, 8'hBB);
    send(8'hFF); send(8'h02); send(8'hAA); send(8'hBB);
    wait_idle();

    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
    send(8'h40);
    send(8'h00);
    check("zero_err_pulse", err, 1);
    check("zero_busy", busy, 0);
    step();
    check("zero_err_len", err, 0);
    check("zero_no_strobes", (wr_cnt - w0) + (rd_cnt - r0), 0);
    check("zero_err_count", err_cnt - e0, 1);
    exp_write(6'h05, 8'h33);
    send(8'h85); send(8'h33);
    wait_idle();

    w0 = wr_cnt;
    exp_write(6'h00, 8'h11);
    send(8'hC0); send(8'h04); send(8'h11);
    frame_abort = 1'b1;
    step();
    frame_abort = 1'b0;
    check("abort_idle", busy, 0);
    step(); step();
    check("abort_one_write", wr_cnt - w0, 1);
    exp_write(6'h06, 8'h44);
    send(8'h86); send(8'h44);
    wait_idle();

    tx_ready = 1'b0;
    w0 = wr_cnt; r0 = rd_cnt;
    send(8'h07);
    step();
    check("pre_rst_txw", tx_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy_mid", busy, 0);
    check("rst_rx_ready_mid", rx_ready, 0);
    step(); step();
    check("rst_no_strobe", {read, write}, 0);
    rst_n = 1'b1;
    tx_ready = 1'b1;
    step(); step();
    check("rst_strobe_count", (wr_cnt - w0) + (rd_cnt - r0), 1);

    check("exp_wr_drained", exp_wr.size(), 0);
    check("exp_tx_drained", exp_tx.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/regs_cmd_ctrl.md
# regs_cmd_ctrl

Command sequencer between the serial byte front end and the PWM register file. It parses a byte stream of read/write commands, with optional burst and address auto-increment. It drives the register file's read/write/addr/data_write strobes and returns read data as a byte stream, so it is the only master of the register file decoder port.

## Interface
- ADDR_W, 6, register address width (wraps modulo 2^ADDR_W)
- DATA_W, 8, byte width of stream and register data
- clk  in  1  peripheral clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- rx_byte  in  8  incoming command/data byte
- rx_valid  in  1  rx_byte valid
- rx_ready  out  1  controller accepts rx_byte; transfer when rx_valid & rx_ready
- tx_byte  out  8  read data byte
- tx_valid  out  1  tx_byte valid
- tx_ready  in  1  sink accepts tx_byte; transfer when tx_valid & tx_ready
- frame_abort  in  1  host ended the frame; drop current command
- read  out  1  register file read strobe
- write  out  1  register file write strobe
- addr  out  6  register address
- data_write  out  8  write data
- data_read  in  8  register file read data, combinational from read/addr
- busy  out  1  state != IDLE
- err  out  1  one-cycle pulse on illegal burst length

## Operation
- Command byte: bit7 = 1 write / 0 read; bit6 = burst; bits5:0 = start address.
- Burst = 1: the next rx byte is length N. N is 1..255. N = 0 pulses err, accepts no further bytes for that command, and returns to IDLE. Burst = 0 means N = 1.
- Write: N data bytes follow. Each byte goes to addr, addr+1, and so on; address wraps 0x3F -> 0x00.
- Read: N reads from addr, addr+1, and so on, with the same wrap. Each result goes out on tx.
- States and transitions:
  - IDLE -> LEN: command accepted with burst = 1.
  - IDLE -> WDATA: write command accepted with burst = 0.
  - IDLE -> RSTB: read command accepted with burst = 0.
  - LEN -> WDATA or RSTB: length byte accepted and N != 0.
  - LEN -> IDLE: N = 0, with err.
  - WDATA -> WPULSE: data byte accepted.
  - WPULSE -> WDATA if remaining > 0, else IDLE.
  - RSTB -> TXW: always.
  - TXW -> RSTB if remaining > 0, else IDLE, on tx handshake.
- rx_ready = 1 only in IDLE, LEN and WDATA, and only while rst_n is high.
- tx_valid = 1 only in TXW.
- write = 1 only in WPULSE. read = 1 only in RSTB.
- data_read is captured into tx_byte at the end of the RSTB cycle.
- tx_byte is held stable while tx_valid = 1 and tx_ready = 0.
- Address increments after each WPULSE and after each tx handshake. The remaining-count decrements at the same points.
- frame_abort has the highest priority: next state is IDLE and the remaining-count clears.
- A strobe already asserted in the abort cycle completes. A byte accepted in the abort cycle is discarded. A pending tx byte is dropped, so tx_valid is low the next cycle.
- addr and data_write hold their last values between strobes; they are don't-care for the register file while strobes are low.

## Timing
- Reset values: state IDLE; read, write, tx_valid, err, busy = 0; addr, data_write, tx_byte = 0; rx_ready = 0 while rst_n is low.
- Single write: command accepted at cycle 0, data accepted at cycle k ≥ 1, write pulse at cycle k+1 for exactly 1 cycle.
- Single read: command accepted at cycle 0, read = 1 at cycle 1, tx_valid = 1 from cycle 2.
- Burst read with tx_ready held high: one byte every 2 cycles.
- Burst write with rx_valid held high: one register every 2 cycles.
- err: 1-cycle pulse in the cycle after the zero length byte is accepted.
- Reset mid-command: asynchronous return to IDLE; no strobe after rst_n falls.

## Structure
- Shared package regs_cmd_pkg holds:
  - state enum: IDLE, LEN, WDATA, WPULSE, RSTB, TXW
  - command bit positions: CMD_WR_BIT = 7, CMD_BURST_BIT = 6
  - ADDR_W and the register address constants, also used by the register file
- No sub-module: a single FSM with address and count registers.

## Test plan
- Single write: rx 0x83, 0x5A -> one write pulse with addr = 0x03, data_write = 0x5A; compare1[7:0] reads back 0x5A.
- Burst write: rx 0xC0, 0x02, 0x10, 0x27 -> writes 0x10 @ 0x00 and 0x27 @ 0x01; period = 0x2710.
- Burst read with backpressure: rx 0x4C, 0x03; tx_ready low for 5 cycles before each handshake -> tx 0x0C, 0x0D, then the value at 0x0E. tx_byte is stable while stalled. Exactly 3 read strobes.
- Address wrap: rx 0xFF, 0x02, 0xAA, 0xBB -> writes 0xAA @ 0x3F and 0xBB @ 0x00.
- Zero length: rx 0x40, 0x00 -> err pulses 1 cycle; no read/write strobes; the next byte is parsed as a command.
- Abort and reset: rx 0xC0, 0x04, 0x11, then frame_abort -> exactly one write; next byte treated as a command. rst_n low during TXW -> tx_valid = 0 immediately and busy = 0.
